// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: registered immediate extender with valid/ready handshake.
// Widens an IN_WIDTH immediate to OUT_WIDTH in sign, zero, upper or branch
// mode and presents the result one cycle after acceptance.
// Optional feature macro: IMM_EXT_SKID_EN adds a skid register so that
// ready_o is a pure register output with no path from ready_i.
module imm_extend_pipe #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [1:0]           mode_i,
  input  logic [IN_WIDTH-1:0]  data_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [OUT_WIDTH-1:0] data_o,
  output logic [1:0]           mode_o
);

  localparam int EXT_W = OUT_WIDTH - IN_WIDTH;

  generate
    if (IN_WIDTH < 2 || OUT_WIDTH < IN_WIDTH + 2) begin : g_bad_params
      $error("imm_extend_pipe: need IN_WIDTH >= 2 and OUT_WIDTH >= IN_WIDTH+2");
    end
  endgenerate

  logic [OUT_WIDTH-1:0] w_sign;
  logic [OUT_WIDTH-1:0] w_ext;
  logic                 w_in_xfer;
  logic                 w_out_free;

  logic                 r_out_valid;
  logic [OUT_WIDTH-1:0] r_out_data;
  logic [1:0]           r_out_mode;

  assign w_sign = {{EXT_W{data_i[IN_WIDTH-1]}}, data_i};

  // Extension is done on the input side so the output register holds final data.
  always_comb begin
    w_ext = w_sign;
    case (mode_i)
      2'b00:   w_ext = w_sign;
      2'b01:   w_ext = {{EXT_W{1'b0}}, data_i};
      2'b10:   w_ext = {data_i, {EXT_W{1'b0}}};
      default: w_ext = {w_sign[OUT_WIDTH-3:0], 2'b00};
    endcase
  end

  // OUT may take new data when it is empty or being consumed this cycle.
  assign w_out_free = !r_out_valid || ready_i;
  assign w_in_xfer  = valid_i && ready_o;

`ifdef IMM_EXT_SKID_EN
  logic                 r_skid_valid;
  logic [OUT_WIDTH-1:0] r_skid_data;
  logic [1:0]           r_skid_mode;

  // Registered ready: the skid slot absorbs the one input accepted while blocked.
  assign ready_o = !r_skid_valid;

  // OUT refills from SKID first (older result), otherwise from the input.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_mode   <= 2'b00;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_mode  <= 2'b00;
    end else begin
      if (w_out_free) begin
        if (r_skid_valid) begin
          r_out_valid  <= 1'b1;
          r_out_data   <= r_skid_data;
          r_out_mode   <= r_skid_mode;
          r_skid_valid <= 1'b0;
        end else if (w_in_xfer) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_ext;
          r_out_mode  <= mode_i;
        end else begin
          r_out_valid <= 1'b0;
        end
      end else if (w_in_xfer) begin
        r_skid_valid <= 1'b1;
        r_skid_data  <= w_ext;
        r_skid_mode  <= mode_i;
      end
    end
  end
`else
  // Single-entry pipeline stage: ready passes straight through from downstream.
  assign ready_o = w_out_free;

  // Load on accept, otherwise empty once the held result has been consumed.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_mode  <= 2'b00;
    end else if (w_in_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_ext;
      r_out_mode  <= mode_i;
    end else if (w_out_free) begin
      r_out_valid <= 1'b0;
    end
  end
`endif

  assign valid_o = r_out_valid;
  assign data_o  = r_out_data;
  assign mode_o  = r_out_mode;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Testbench for imm_extend_pipe: scoreboard with a behavioural extension model,
// directed vectors, backpressure, throughput, reset and a 12->24 instance.
module tb_imm_extend_pipe;

  typedef struct {
    logic [63:0] d;
    logic [1:0]  m;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        vi = 1'b0, ro, vo, ri = 1'b0;
  logic [1:0]  mi = 2'b00, mo;
  logic [15:0] di = '0;
  logic [31:0] dout;

  logic        vi2 = 1'b0, ro2, vo2, ri2 = 1'b0;
  logic [1:0]  mi2 = 2'b00, mo2;
  logic [11:0] di2 = '0;
  logic [23:0] dout2;

  exp_t q1[$];
  exp_t q2[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   out_cnt = 0;

  always #5 clk = ~clk;

  imm_extend_pipe #(.IN_WIDTH(16), .OUT_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(vi), .ready_o(ro), .mode_i(mi),
    .data_i(di), .valid_o(vo), .ready_i(ri), .data_o(dout), .mode_o(mo));

  imm_extend_pipe #(.IN_WIDTH(12), .OUT_WIDTH(24)) dut2 (
    .clk_i(clk), .rst_i(rst), .valid_i(vi2), .ready_o(ro2), .mode_i(mi2),
    .data_i(di2), .valid_o(vo2), .ready_i(ri2), .data_o(dout2), .mode_o(mo2));

  // Reference: interpret the immediate as a number and rebuild it arithmetically.
  function automatic logic [63:0] ref_ext(int iw, int ow, logic [63:0] d, int m);
    logic [63:0] mask;
    logic [63:0] s;
    mask = (64'd1 << ow) - 64'd1;
    s = d;
    if (d[iw-1]) s = d - (64'd1 << iw);
    case (m)
      0:       return s & mask;
      1:       return d & mask;
      2:       return (d << (ow - iw)) & mask;
      default: return (s * 64'd4) & mask;
    endcase
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Input side of the scoreboard: every accepted input predicts one result.
  always @(posedge clk) begin
    if (rst) begin
      q1.delete();
      q2.delete();
    end else begin
      if (vi && ro)
        q1.push_back('{ref_ext(16, 32, 64'(di), int'(mi)), mi});
      if (vi2 && ro2)
        q2.push_back('{ref_ext(12, 24, 64'(di2), int'(mi2)), mi2});
    end
  end

  // Output side: whatever is presented must match the oldest prediction.
  always @(negedge clk) begin
    if (vo) begin
      if (q1.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_out: got %h expected nothing", dout);
      end else begin
        chk("data_o", 64'(dout), q1[0].d);
        chk("mode_o", 64'(mo), 64'(q1[0].m));
        if (ri) begin
          void'(q1.pop_front());
          out_cnt++;
        end
      end
    end
    if (vo2) begin
      if (q2.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_out2: got %h expected nothing", dout2);
      end else begin
        chk("data_o2", 64'(dout2), q2[0].d);
        chk("mode_o2", 64'(mo2), 64'(q2[0].m));
        if (ri2) void'(q2.pop_front());
      end
    end
  end

  task automatic send(logic [15:0] d, logic [1:0] m);
    logic acc;
    acc = 1'b0;
    vi = 1'b1; di = d; mi = m;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      if (ro) begin
        acc = 1'b1;
        break;
      end
    end
    chk("accept_timeout", 64'(acc), 64'd1);
    #1 vi = 1'b0;
  endtask

  task automatic send_exp(string name, logic [15:0] d, logic [1:0] m, logic [31:0] exp);
    send(d, m);
    @(negedge clk);
    chk({name, "_valid"}, 64'(vo), 64'd1);
    chk(name, 64'(dout), 64'(exp));
  endtask

  task automatic drain();
    vi = 1'b0; ri = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #2;
      if (q1.size() == 0 && !vo) break;
    end
    chk("drain_empty", 64'(q1.size()), 64'd0);
  endtask

  initial begin
    logic [3:0] pat;
    logic       bp_done;
    logic       acc1, acc2;
    int         cnt0, vcnt;

    // Reset state
    ri = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid_o", 64'(vo), 64'd0);
    chk("rst_data_o",  64'(dout), 64'd0);
    chk("rst_mode_o",  64'(mo), 64'd0);
    chk("rst_ready_o", 64'(ro), 64'd1);

    // Directed vectors, back to back
    send_exp("sign_8004",   16'h8004, 2'b00, 32'hFFFF8004);
    send_exp("zero_8004",   16'h8004, 2'b01, 32'h00008004);
    send_exp("upper_8004",  16'h8004, 2'b10, 32'h80040000);
    send_exp("branch_8004", 16'h8004, 2'b11, 32'hFFFE0010);
    send_exp("branch_ffff", 16'hFFFF, 2'b11, 32'hFFFFFFFC);
    send_exp("sign_7fff",   16'h7FFF, 2'b00, 32'h00007FFF);
    send_exp("upper_1234",  16'h1234, 2'b10, 32'h12340000);
    drain();

    // Backpressure with ready_i pattern 1,0,0,1
    pat = 4'b1001;
    bp_done = 1'b0;
    cnt0 = out_cnt;
    @(negedge clk);
    ri = pat[0];
    fork
      begin
        for (int n = 1; n <= 8; n++) send(16'(n), 2'b01);
        bp_done = 1'b1;
      end
      begin
        for (int k = 1; k < 400 && !bp_done; k++) begin
          @(posedge clk); #1;
          ri = pat[k % 4];
        end
      end
    join
    drain();
    chk("bp_count", 64'(out_cnt - cnt0), 64'd8);

`ifdef IMM_EXT_SKID_EN
    // Second accept while blocked fills SKID; ready_o drops after that edge
    @(negedge clk);
    ri = 1'b0;
    send(16'h0011, 2'b00);
    chk("skid_ready_after_1", 64'(ro), 64'd1);
    send(16'h0022, 2'b00);
    chk("skid_ready_after_2", 64'(ro), 64'd0);
    drain();
    chk("skid_ready_after_drain", 64'(ro), 64'd1);
`endif

    // Full throughput: 10 results with valid_o continuously high
    @(negedge clk); #1;
    ri = 1'b1;
    vcnt = 0;
    fork
      begin
        for (int n = 0; n < 10; n++) send(16'($urandom), 2'($urandom_range(0, 3)));
      end
      begin
        repeat (10) begin
          @(negedge clk);
          if (vo) vcnt++;
        end
      end
    join
    chk("throughput_valid_cycles", 64'(vcnt), 64'd10);
    drain();

    // Reset mid-stream with held results
    @(negedge clk);
    ri = 1'b0;
    send(16'hAAAA, 2'b01);
`ifdef IMM_EXT_SKID_EN
    send(16'h5555, 2'b01);
`endif
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid_o", 64'(vo), 64'd0);
    chk("midrst_data_o",  64'(dout), 64'd0);
    chk("midrst_mode_o",  64'(mo), 64'd0);
    chk("midrst_ready_o", 64'(ro), 64'd1);
    ri = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_stale", 64'(vo), 64'd0);
    end

    // 12->24 instance, directed branch vector
    @(negedge clk);
    ri2 = 1'b1; vi2 = 1'b1; di2 = 12'h800; mi2 = 2'b11;
    @(posedge clk);
    chk("p12_ready", 64'(ro2), 64'd1);
    #1 vi2 = 1'b0;
    @(negedge clk);
    chk("p12_branch_800", 64'(dout2), 64'hFFE000);

    // Random traffic on both instances, holding inputs until accepted
    acc1 = 1'b0; acc2 = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 600; c++) begin
      if (!vi || acc1) begin
        vi = ($urandom_range(0, 3) != 0);
        di = 16'($urandom);
        mi = 2'($urandom_range(0, 3));
      end
      if (!vi2 || acc2) begin
        vi2 = ($urandom_range(0, 3) != 0);
        di2 = 12'($urandom);
        mi2 = 2'($urandom_range(0, 3));
      end
      ri  = ($urandom_range(0, 2) != 0);
      ri2 = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      acc1 = vi && ro;
      acc2 = vi2 && ro2;
      #1;
    end
    vi2 = 1'b0; ri2 = 1'b1;
    drain();
    repeat (4) @(posedge clk);
    #2;
    chk("final_q2_empty", 64'(q2.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
